// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pci_pkg
//  Description : Definitions shared by the PCI master bridge and its Avalon
//                front end. Holds the PCI command codes, the default
//                master-abort read value, the burst splitter state encoding
//                and the burst-length clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pci_pkg;

    // PCI bus command codes, also used by the bridge.
    localparam logic [3:0] CMD_IO_READ   = 4'h2;
    localparam logic [3:0] CMD_IO_WRITE  = 4'h3;
    localparam logic [3:0] CMD_MEM_READ  = 4'h6;
    localparam logic [3:0] CMD_MEM_WRITE = 4'h7;
    localparam logic [3:0] CMD_CFG_READ  = 4'hA;
    localparam logic [3:0] CMD_CFG_WRITE = 4'hB;

    // A master abort on PCI reads back as all ones.
    localparam logic [31:0] c_ABORT_DATA = 32'hFFFF_FFFF;
    localparam int          c_MAX_BURST  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_BEAT  = 3'd4
    } state_t;

    // A burstcount of 0 means one beat; anything above max_burst is cut down.
    function automatic logic [3:0] clamp_burst(input logic [3:0] count,
                                               input logic [3:0] max_burst);
        if (count == 4'd0)
            return 4'd1;
        else if (count > max_burst)
            return max_burst;
        else
            return count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_read_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : pci_read_timeout
//  Description : Read-response watchdog for the burst splitter. Counts cycles
//                spent waiting for bridge read data, flags a timeout, and
//                tracks one outstanding late (stale) response so that it is
//                swallowed instead of being taken as a later beat's data.
//  Ports       : clk, rst_n   - clock, synchronous active-low reset
//                i_start      - bridge accepted a read; restart the count
//                i_waiting    - splitter is waiting for read data
//                i_rdv        - bridge m_readdatavalid
//                o_beat       - genuine read beat for the current request
//                o_timeout    - current request has timed out this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_read_timeout #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_waiting,
    input  logic i_rdv,
    output logic o_beat,
    output logic o_timeout
);

    localparam logic [6:0] c_TMO_LAST = 7'(TIMEOUT_CYCLES - 1);

    logic [6:0] r_tmo;
    logic       r_stale;

    // A response that arrives while stale is set belongs to an earlier,
    // already-aborted read, so it never counts as the current beat.
    always_comb begin
        o_beat    = i_waiting && i_rdv && !r_stale;
        o_timeout = i_waiting && (r_tmo == c_TMO_LAST) && !o_beat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo   <= 7'd0;
            r_stale <= 1'b0;
        end else begin
            if (i_start)
                r_tmo <= 7'd0;
            else if (i_waiting && (r_tmo != c_TMO_LAST))
                r_tmo <= r_tmo + 7'd1;

            // The late response is dropped in any state. A fresh timeout
            // keeps the flag set, but only one late beat is ever absorbed.
            if (o_timeout)
                r_stale <= 1'b1;
            else if (i_rdv)
                r_stale <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pci_avm_burst_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : pci_avm_burst_splitter
//  Description : Splits Avalon bursts of 1..MAX_BURST beats into single-beat
//                transfers for the PCI master bridge, collects read data and
//                substitutes ABORT_DATA for reads the bridge never answers.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                s_*               - upstream Avalon slave (burst capable)
//                m_*               - downstream single-beat Avalon master
//                abort_flag        - sticky read-timeout indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_avm_burst_splitter
    import pci_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ABORT_DATA     = c_ABORT_DATA,
    parameter int          MAX_BURST      = c_MAX_BURST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] s_address,
    input  logic [3:0]  s_burstcount,
    input  logic [3:0]  s_byteenable,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic        s_readdatavalid,
    output logic [31:0] s_readdata,
    output logic [21:0] m_address,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic [3:0]  m_burstcount,
    output logic        m_read,
    output logic        m_write,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    output logic        abort_flag
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;        // low for the cycle after reset to hold off upstream
    logic [21:0] r_beat_addr;
    logic [3:0]  r_beats_left;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_rdv;
    logic        r_abort;

    logic        w_start;
    logic        w_waiting;
    logic        w_beat;
    logic        w_timeout;
    logic        w_last_beat;

    assign w_start     = (r_state == RD_ISSUE) && !m_waitrequest;
    assign w_waiting   = (r_state == RD_WAIT);
    assign w_last_beat = (r_beats_left == 4'd1);

    pci_read_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_waiting (w_waiting),
        .i_rdv     (m_readdatavalid),
        .o_beat    (w_beat),
        .o_timeout (w_timeout)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                // Write wins a simultaneous request; the read stays stalled.
                if (r_ready && s_write)
                    w_state_next = WR_ISSUE;
                else if (r_ready && s_read)
                    w_state_next = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (!m_waitrequest)
                    w_state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (w_beat || w_timeout)
                    w_state_next = w_last_beat ? IDLE : RD_ISSUE;
            end
            WR_ISSUE: begin
                if (!m_waitrequest)
                    w_state_next = w_last_beat ? IDLE : WR_BEAT;
            end
            WR_BEAT: begin
                if (s_write)
                    w_state_next = WR_ISSUE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        s_waitrequest = !(r_ready && ((r_state == IDLE) || (r_state == WR_BEAT)));
        m_read        = (r_state == RD_ISSUE);
        m_write       = (r_state == WR_ISSUE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_beat_addr  <= 22'd0;
            r_beats_left <= 4'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_rdata      <= 32'd0;
            r_rdv        <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_rdv   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_ready && (s_write || s_read)) begin
                        r_beat_addr  <= s_address;
                        r_beats_left <= clamp_burst(s_burstcount, 4'(MAX_BURST));
                        if (s_write) begin
                            r_wdata <= s_writedata;
                            r_be    <= s_byteenable;
                        end
                    end
                end
                RD_WAIT: begin
                    // A timed-out beat advances exactly like a real one.
                    if (w_beat || w_timeout) begin
                        r_rdv        <= 1'b1;
                        r_rdata      <= w_beat ? m_readdata : ABORT_DATA;
                        r_beat_addr  <= r_beat_addr + 22'd1;
                        r_beats_left <= r_beats_left - 4'd1;
                        if (w_timeout)
                            r_abort <= 1'b1;
                    end
                end
                WR_ISSUE: begin
                    if (!m_waitrequest && !w_last_beat) begin
                        r_beat_addr  <= r_beat_addr + 22'd1;
                        r_beats_left <= r_beats_left - 4'd1;
                    end
                end
                WR_BEAT: begin
                    if (s_write) begin
                        r_wdata <= s_writedata;
                        r_be    <= s_byteenable;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_readdatavalid = r_rdv;
    assign s_readdata      = r_rdata;
    assign m_address       = r_beat_addr;
    assign m_writedata     = r_wdata;
    assign m_byteenable    = r_be;
    assign m_burstcount    = 4'd1;
    assign abort_flag      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_pci_avm_burst_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_avm_burst_splitter
//  Description : Self-checking bench for pci_avm_burst_splitter. A bridge
//                model logs every accepted single-beat transfer and answers
//                reads after a chosen latency; expected transfer lists and
//                read data come from the burst rules applied directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_avm_burst_splitter;

    localparam int c_TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] s_address = '0;
    logic [3:0]  s_burstcount = '0;
    logic [3:0]  s_byteenable = '0;
    logic [31:0] s_writedata = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic        s_waitrequest;
    logic        s_readdatavalid;
    logic [31:0] s_readdata;
    logic [21:0] m_address;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [3:0]  m_burstcount;
    logic        m_read;
    logic        m_write;
    logic        m_waitrequest;
    logic        m_readdatavalid;
    logic [31:0] m_readdata;
    logic        abort_flag;

    pci_avm_burst_splitter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_address       (s_address),
        .s_burstcount    (s_burstcount),
        .s_byteenable    (s_byteenable),
        .s_writedata     (s_writedata),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_waitrequest   (s_waitrequest),
        .s_readdatavalid (s_readdatavalid),
        .s_readdata      (s_readdata),
        .m_address       (m_address),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_burstcount    (m_burstcount),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .abort_flag      (abort_flag)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          wr;
        logic [21:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          c;
    } btxn_t;

    btxn_t       blog[$];
    logic [31:0] up_q[$];
    int          up_c[$];

    int          br_wait_pct = 0;
    int          br_lat_min  = 1;
    int          br_lat_max  = 1;
    bit          br_mute     = 1'b0;
    bit          br_force_en = 1'b0;
    logic [31:0] br_force_data = '0;
    bit          br_inject   = 1'b0;

    function automatic logic [31:0] rd_value(input logic [21:0] a);
        return {a[9:0], a} ^ 32'h5A0F_C3E1;
    endfunction

    function automatic int beats_of(input logic [3:0] n);
        if (n == 4'd0) return 1;
        if (n > 4'd8)  return 8;
        return int'(n);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Upstream read beat monitor.
    initial forever begin
        @(negedge clk);
        if (rst_n && s_readdatavalid) begin
            up_q.push_back(s_readdata);
            up_c.push_back(cyc);
        end
    end

    // Bridge model: random stall, logs accepted beats, answers reads.
    initial begin
        bit          pend = 1'b0;
        int          cnt = 0;
        logic [31:0] pdata = '0;
        bit          prev_stall = 1'b0;
        logic        prev_rd = 1'b0, prev_wr = 1'b0;
        logic [21:0] prev_addr = '0;
        logic [31:0] prev_wd = '0;
        logic [3:0]  prev_be = '0;
        btxn_t       t;
        m_waitrequest   = 1'b1;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        forever begin
            @(negedge clk);
            m_readdatavalid = 1'b0;
            if (!rst_n) begin
                pend          = 1'b0;
                prev_stall    = 1'b0;
                m_waitrequest = 1'b1;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (m_read !== prev_rd || m_write !== prev_wr || m_address !== prev_addr ||
                        (prev_wr && (m_writedata !== prev_wd || m_byteenable !== prev_be))) begin
                        bad++;
                        $display("FAIL hold_while_stalled: rd=%b wr=%b addr=%h wd=%h, required rd=%b wr=%b addr=%h wd=%h",
                                 m_read, m_write, m_address, m_writedata, prev_rd, prev_wr, prev_addr, prev_wd);
                    end
                end
                if (m_read || m_write) begin
                    total++;
                    if (m_read && m_write || m_burstcount !== 4'd1) begin
                        bad++;
                        $display("FAIL master_exclusive: rd=%b wr=%b burst=%0d, required one of rd/wr and burst=1",
                                 m_read, m_write, m_burstcount);
                    end
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend            = 1'b0;
                        m_readdatavalid = 1'b1;
                        m_readdata      = pdata;
                    end
                end
                if (br_inject) begin
                    br_inject       = 1'b0;
                    m_readdatavalid = 1'b1;
                    m_readdata      = 32'hDEAD_BEEF;
                end
                if (m_read || m_write) begin
                    m_waitrequest = (int'($urandom_range(99)) < br_wait_pct);
                    if (!m_waitrequest) begin
                        t.wr = m_write; t.addr = m_address; t.data = m_writedata;
                        t.be = m_byteenable; t.c = cyc + 1;
                        blog.push_back(t);
                        if (m_read && !br_mute) begin
                            pend  = 1'b1;
                            cnt   = int'($urandom_range(br_lat_max, br_lat_min));
                            pdata = br_force_en ? br_force_data : rd_value(m_address);
                        end
                    end
                end else begin
                    m_waitrequest = ($urandom_range(1) == 1);
                end
                prev_stall = (m_read || m_write) && m_waitrequest;
                prev_rd = m_read; prev_wr = m_write; prev_addr = m_address;
                prev_wd = m_writedata; prev_be = m_byteenable;
            end
        end
    end

    // ------------------------------------------------------ stimulus helpers
    task automatic clear_logs();
        blog.delete();
        up_q.delete();
        up_c.delete();
    endtask

    task automatic wait_beats(input int n, input int bound);
        for (int i = 0; i < bound && up_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int bound);
        for (int i = 0; i < bound && blog.size() < n; i++) @(negedge clk);
    endtask

    task automatic up_read(input logic [21:0] a, input logic [3:0] n);
        @(negedge clk);
        s_address = a; s_burstcount = n; s_read = 1'b1;
        for (int i = 0; i < 500 && s_waitrequest; i++) @(negedge clk);
        @(negedge clk);
        s_read = 1'b0;
    endtask

    task automatic up_write(input logic [21:0] a, input logic [3:0] n,
                            input logic [31:0] wd[8], input logic [3:0] be[8], input int gap);
        int nb;
        nb = beats_of(n);
        @(negedge clk);
        s_address = a; s_burstcount = n;
        for (int b = 0; b < nb; b++) begin
            s_writedata = wd[b]; s_byteenable = be[b]; s_write = 1'b1;
            for (int i = 0; i < 500 && s_waitrequest; i++) @(negedge clk);
            @(negedge clk);
            if (b == nb - 1 || gap > 0) s_write = 1'b0;
            if (b != nb - 1) repeat (gap) @(negedge clk);
        end
        s_write = 1'b0;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (s_waitrequest !== 1'b1 || s_readdatavalid !== 1'b0 || s_readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_upstream: wreq=%b rdv=%b rdata=%h, required 1 0 00000000",
                     s_waitrequest, s_readdatavalid, s_readdata);
        end
        total++;
        if (m_read !== 1'b0 || m_write !== 1'b0 || m_address !== 22'd0 || m_writedata !== 32'd0 ||
            m_byteenable !== 4'd0 || abort_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_master: rd=%b wr=%b addr=%h wd=%h be=%b abort=%b, required all zero",
                     m_read, m_write, m_address, m_writedata, m_byteenable, abort_flag);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        clear_logs();
        br_wait_pct = 0; br_lat_min = 5; br_lat_max = 5;
        br_force_en = 1'b1; br_force_data = 32'h1234_ABCD;
        up_read(22'h000010, 4'd1);
        wait_beats(1, 100);
        repeat (3) @(negedge clk);
        br_force_en = 1'b0;
        total++;
        if (up_q.size() != 1 || blog.size() != 1) begin
            bad++;
            $display("FAIL single_read_count: beats=%0d bridge=%0d, required 1 1", up_q.size(), blog.size());
        end else begin
            total++;
            if (up_q[0] !== 32'h1234_ABCD || blog[0].addr !== 22'h000010 || blog[0].wr) begin
                bad++;
                $display("FAIL single_read_data: data=%h addr=%h, required 1234abcd 000010", up_q[0], blog[0].addr);
            end
            total++;
            if (up_c[0] - blog[0].c != 5) begin
                bad++;
                $display("FAIL single_read_latency: %0d, required 5", up_c[0] - blog[0].c);
            end
        end
        total++;
        if (abort_flag !== 1'b0) begin
            bad++;
            $display("FAIL single_read_abort: %b, required 0", abort_flag);
        end
    endtask

    task automatic test_read_wrap();
        logic [21:0] ea;
        clear_logs();
        br_wait_pct = 30; br_lat_min = 1; br_lat_max = 4;
        up_read(22'h3FFFFE, 4'd4);
        wait_beats(4, 300);
        repeat (3) @(negedge clk);
        total++;
        if (up_q.size() != 4 || blog.size() != 4) begin
            bad++;
            $display("FAIL wrap_count: beats=%0d bridge=%0d, required 4 4", up_q.size(), blog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = 22'h3FFFFE + 22'(i);
                total++;
                if (blog[i].addr !== ea || up_q[i] !== rd_value(ea)) begin
                    bad++;
                    $display("FAIL wrap_beat%0d: addr=%h data=%h, required %h %h", i, blog[i].addr, up_q[i], ea, rd_value(ea));
                end
            end
        end
    endtask

    task automatic test_write_paused();
        logic [31:0] wd[3];
        logic [3:0]  be[3];
        int          viol;
        clear_logs();
        br_wait_pct = 0;
        wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0001; wd[2] = 32'h3333_0002;
        be[0] = 4'hF; be[1] = 4'b0011; be[2] = 4'hF;
        viol = 0;
        @(negedge clk);
        s_address = 22'h00_0100; s_burstcount = 4'd3;
        for (int b = 0; b < 3; b++) begin
            s_writedata = wd[b]; s_byteenable = be[b]; s_write = 1'b1;
            for (int i = 0; i < 100 && s_waitrequest; i++) @(negedge clk);
            @(negedge clk);
            s_write = 1'b0;
            if (b < 2) begin
                for (int g = 0; g < 2; g++) begin
                    if (!m_write && s_waitrequest) viol++;
                    @(negedge clk);
                end
            end
        end
        wait_log(3, 50);
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL write_pause_wreq: %0d stalled pause cycles, required 0", viol);
        end
        total++;
        if (blog.size() != 3) begin
            bad++;
            $display("FAIL write_count: %0d, required 3", blog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (!blog[i].wr || blog[i].addr !== 22'h100 + 22'(i) || blog[i].data !== wd[i] || blog[i].be !== be[i]) begin
                    bad++;
                    $display("FAIL write_beat%0d: addr=%h data=%h be=%b, required %h %h %b",
                             i, blog[i].addr, blog[i].data, blog[i].be, 22'h100 + 22'(i), wd[i], be[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        br_wait_pct = 0; br_mute = 1'b1;
        up_read(22'h000200, 4'd1);
        wait_beats(1, 200);
        total++;
        if (up_q.size() != 1 || blog.size() != 1) begin
            bad++;
            $display("FAIL timeout_count: beats=%0d bridge=%0d, required 1 1", up_q.size(), blog.size());
        end else begin
            total++;
            if (up_q[0] !== 32'hFFFF_FFFF || up_c[0] - blog[0].c != c_TMO) begin
                bad++;
                $display("FAIL timeout_beat: data=%h after=%0d, required ffffffff %0d", up_q[0], up_c[0] - blog[0].c, c_TMO);
            end
        end
        total++;
        if (abort_flag !== 1'b1) begin
            bad++;
            $display("FAIL timeout_abort_flag: %b, required 1", abort_flag);
        end
        repeat (10) @(negedge clk);
        br_inject = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (up_q.size() != 1 || abort_flag !== 1'b1) begin
            bad++;
            $display("FAIL timeout_late_dropped: beats=%0d abort=%b, required 1 1", up_q.size(), abort_flag);
        end
        br_mute = 1'b0;
        clear_logs();
        br_lat_min = 2; br_lat_max = 3;
        up_read(22'h000300, 4'd2);
        wait_beats(2, 200);
        repeat (3) @(negedge clk);
        total++;
        if (up_q.size() != 2 || up_q[0] !== rd_value(22'h300) || up_q[1] !== rd_value(22'h301)) begin
            bad++;
            $display("FAIL after_timeout_read: beats=%0d first=%h, required 2 %h", up_q.size(),
                     (up_q.size() > 0) ? up_q[0] : 32'h0, rd_value(22'h300));
        end
    endtask

    task automatic test_rw_collision();
        clear_logs();
        br_wait_pct = 20; br_lat_min = 1; br_lat_max = 3;
        @(negedge clk);
        s_address = 22'h000040; s_burstcount = 4'd1;
        s_writedata = 32'hCAFE_F00D; s_byteenable = 4'hF;
        s_read = 1'b1; s_write = 1'b1;
        for (int i = 0; i < 100 && s_waitrequest; i++) @(negedge clk);
        @(negedge clk);
        s_write = 1'b0;
        for (int i = 0; i < 100 && s_waitrequest; i++) @(negedge clk);
        @(negedge clk);
        s_read = 1'b0;
        wait_beats(1, 100);
        repeat (3) @(negedge clk);
        total++;
        if (blog.size() != 2 || up_q.size() != 1) begin
            bad++;
            $display("FAIL collision_count: bridge=%0d beats=%0d, required 2 1", blog.size(), up_q.size());
        end else begin
            total++;
            if (!blog[0].wr || blog[0].data !== 32'hCAFE_F00D || blog[1].wr || blog[1].addr !== 22'h40 ||
                up_q[0] !== rd_value(22'h40)) begin
                bad++;
                $display("FAIL collision_order: first_wr=%b second_wr=%b data=%h, required 1 0 %h",
                         blog[0].wr, blog[1].wr, up_q[0], rd_value(22'h40));
            end
        end
    endtask

    task automatic test_reset_midburst();
        clear_logs();
        br_wait_pct = 0; br_lat_min = 20; br_lat_max = 20;
        up_read(22'h000500, 4'd4);
        wait_log(1, 50);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (s_waitrequest !== 1'b1 || s_readdatavalid !== 1'b0 || s_readdata !== 32'd0 || m_read !== 1'b0 ||
            m_write !== 1'b0 || m_address !== 22'd0 || m_byteenable !== 4'd0 || abort_flag !== 1'b0) begin
            bad++;
            $display("FAIL midburst_reset: wreq=%b rdv=%b rd=%b addr=%h abort=%b, required 1 0 0 000000 0",
                     s_waitrequest, s_readdatavalid, m_read, m_address, abort_flag);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        br_lat_min = 1; br_lat_max = 2;
        up_read(22'h000600, 4'd1);
        wait_beats(1, 100);
        repeat (3) @(negedge clk);
        total++;
        if (up_q.size() != 1 || blog.size() != 1 || up_q[0] !== rd_value(22'h600)) begin
            bad++;
            $display("FAIL midburst_recover: beats=%0d bridge=%0d, required 1 1 data %h",
                     up_q.size(), blog.size(), rd_value(22'h600));
        end
    endtask

    task automatic test_random();
        logic [21:0] a, ea;
        logic [3:0]  n;
        logic [31:0] wd[8];
        logic [3:0]  be[8];
        int          nb, errs;
        bit          is_wr;
        for (int t = 0; t < 30; t++) begin
            clear_logs();
            br_wait_pct = int'($urandom_range(60));
            br_lat_min  = 1;
            br_lat_max  = int'($urandom_range(4, 1));
            a = ($urandom_range(3) == 0) ? 22'h3FFFFC + 22'($urandom_range(3)) : 22'($urandom);
            n = 4'($urandom_range(15));
            nb = beats_of(n);
            is_wr = $urandom_range(1) == 1;
            if (is_wr) begin
                for (int i = 0; i < 8; i++) begin
                    wd[i] = $urandom;
                    be[i] = 4'($urandom);
                end
                up_write(a, n, wd, be, int'($urandom_range(3)));
                wait_log(nb, 200);
            end else begin
                up_read(a, n);
                wait_beats(nb, 100 * nb + 100);
            end
            repeat (3) @(negedge clk);
            total++;
            if (blog.size() != nb || (!is_wr && up_q.size() != nb)) begin
                bad++;
                $display("FAIL random%0d_count: wr=%b bridge=%0d beats=%0d, required %0d",
                         t, is_wr, blog.size(), up_q.size(), nb);
            end else begin
                errs = 0;
                for (int i = 0; i < nb; i++) begin
                    ea = a + 22'(i);
                    if (blog[i].wr != is_wr || blog[i].addr !== ea) errs++;
                    if (is_wr && (blog[i].data !== wd[i] || blog[i].be !== be[i])) errs++;
                    if (!is_wr && up_q[i] !== rd_value(ea)) errs++;
                end
                total++;
                if (errs != 0) begin
                    bad++;
                    $display("FAIL random%0d_beats: wr=%b addr=%h n=%0d wrong_fields=%0d, required 0",
                             t, is_wr, a, n, errs);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_read_wrap();
        test_write_paused();
        test_rw_collision();
        test_reset_midburst();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
